mips_mem_responder: RTL and testbench

- Host-side responder for the byte-serial memory bus that the MIPS core drives over its 8-bit bidirectional pins.
- Accepts framed read/write word requests one byte per handshake and services them from a local word RAM.
- Returns response bytes over a separate valid/ready channel.
- Used on FPGA/bench harnesses as the memory the core fetches from, and as the synthesizable peer for protocol checks.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/mips_mem_ram.sv | 28 ++
 rtl/mips_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mips_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared command codes, response codes and FSM states for the MIPS memory responder
package mips_mem_pkg;

   localparam logic [7:0] CMD_READ  = 8'h01;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] RSP_ACK   = 8'hA5;
   localparam logic [7:0] RSP_ERR   = 8'hEE;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      EXEC,
      RESP,
      ERR
   } state_e;

endpackage

// File: rtl/mips_mem_ram.sv
// rtl/mips_mem_ram.sv - word RAM with synchronous write and one-cycle registered read
module mips_mem_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;

   // Read data only moves on a read strobe so it stays put while the response is serialised.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - byte-serial framed read/write responder backed by a local word RAM
module mips_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [7:0] req_byte,
   output logic       req_ready,
   output logic       rsp_valid,
   output logic [7:0] rsp_byte,
   input  logic       rsp_ready,
   output logic       frame_err
);

   localparam int         AW       = ADDR_W + 2;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [7:0]      tmo_q, tmo_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic            is_wr_q, is_wr_d;
   logic            err_q, err_d;
   logic            ram_we, ram_re;
   logic [31:0]     ram_rdata;
   logic            rsp_fire;

   assign req_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA);
   assign rsp_valid = (state_q == RESP) || (state_q == ERR);
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign frame_err = err_q;

   always_comb begin
      rsp_byte = 8'h00;
      if (state_q == ERR) begin
         rsp_byte = RSP_ERR;
      end else if (state_q == RESP) begin
         if (is_wr_q) begin
            rsp_byte = RSP_ACK;
         end else begin
            case (cnt_q)
               2'd0:    rsp_byte = ram_rdata[31:24];
               2'd1:    rsp_byte = ram_rdata[23:16];
               2'd2:    rsp_byte = ram_rdata[15:8];
               default: rsp_byte = ram_rdata[7:0];
            endcase
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      addr_d  = addr_q;
      data_d  = data_q;
      is_wr_d = is_wr_q;
      err_d   = 1'b0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_d   = 2'd0;
               tmo_d   = 8'd0;
               is_wr_d = (req_byte == CMD_WRITE);
               if (req_byte == CMD_READ || req_byte == CMD_WRITE) begin
                  state_d = ADDR;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
         ADDR, WDATA: begin
            if (req_valid) begin
               tmo_d = 8'd0;
               cnt_d = cnt_q + 2'd1;
               if (state_q == ADDR) begin
                  // Only the word index and alignment bits are kept; higher address bits alias.
                  addr_d = AW'({addr_q, req_byte});
               end else begin
                  data_d = {data_q[23:0], req_byte};
               end
               if (cnt_q == 2'd3) begin
                  if (state_q == WDATA) begin
                     state_d = EXEC;
                  end else if (req_byte[1:0] != 2'b00) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end else begin
                     state_d = is_wr_q ? WDATA : EXEC;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = IDLE;
               tmo_d   = 8'd0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         EXEC: begin
            ram_we  = is_wr_q;
            ram_re  = !is_wr_q;
            cnt_d   = 2'd0;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_fire) begin
               if (is_wr_q || cnt_q == 2'd3) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         ERR: begin
            if (rsp_fire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         tmo_q   <= 8'd0;
         addr_q  <= '0;
         data_q  <= 32'd0;
         is_wr_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         is_wr_q <= is_wr_d;
         err_q   <= err_d;
      end
   end

   mips_mem_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .re   (ram_re),
      .addr (addr_q[AW-1:2]),
      .wdata(data_q),
      .rdata(ram_rdata)
   );

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed and randomized frame checks against a frame-level memory model
module tb_mips_mem_responder;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 255;
   localparam int WORDS   = 2**ADDR_W;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [7:0] req_byte;
   logic       req_ready;
   logic       rsp_valid;
   logic [7:0] rsp_byte;
   logic       rsp_ready;
   logic       frame_err;

   int passed  = 0;
   int total   = 0;
   int err_cnt = 0;

   logic [31:0] ref_mem [WORDS];
   int          known_q[$];
   logic [7:0]  frm[$];
   logic [7:0]  exp_q[$];
   bit          exp_err;

   mips_mem_responder #(
      .ADDR_W (ADDR_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_byte (req_byte),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_byte (rsp_byte),
      .rsp_ready(rsp_ready),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      req_valid = 1'b0;
      repeat (gap) @(negedge clk);
      req_valid = 1'b1;
      req_byte  = b;
      while (req_ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) check("req_ready_wait", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Frame-level model: decides the response bytes and error flag, and commits writes.
   function automatic void build_expect();
      logic [31:0] a;
      logic [31:0] d;
      int          idx;
      exp_q.delete();
      exp_err = 1'b0;
      if (frm[0] != 8'h01 && frm[0] != 8'h02) begin
         exp_q.push_back(8'hEE);
         exp_err = 1'b1;
         return;
      end
      a = {frm[1], frm[2], frm[3], frm[4]};
      if (a[1:0] != 2'b00) begin
         exp_q.push_back(8'hEE);
         exp_err = 1'b1;
         return;
      end
      idx = int'(a >> 2) % WORDS;
      if (frm[0] == 8'h02) begin
         d = {frm[5], frm[6], frm[7], frm[8]};
         ref_mem[idx] = d;
         if (!(idx inside {known_q})) known_q.push_back(idx);
         exp_q.push_back(8'hA5);
      end else begin
         d = ref_mem[idx];
         exp_q.push_back(d[31:24]);
         exp_q.push_back(d[23:16]);
         exp_q.push_back(d[15:8]);
         exp_q.push_back(d[7:0]);
      end
   endfunction

   task automatic run_frame(input string tag, input bit stall, input int gap);
      int         off;
      int         first_valid;
      int         k;
      int         e0;
      int         bad_rr;
      bit         prev_stall;
      logic [7:0] prev_byte;
      logic [7:0] got[$];
      logic [3:0] pat;
      logic [7:0] obs;
      pat         = 4'b1001;
      off         = 1;
      first_valid = -1;
      k           = 0;
      bad_rr      = 0;
      prev_stall  = 1'b0;
      prev_byte   = 8'h00;
      build_expect();
      e0 = err_cnt;
      foreach (frm[i]) send_byte(frm[i], gap);
      while (got.size() < exp_q.size() && off < 60) begin
         rsp_ready = stall ? pat[k % 4] : 1'b1;
         k++;
         if (rsp_valid === 1'b1) begin
            if (first_valid < 0) first_valid = off;
            if (prev_stall) check({tag, "_hold"}, 32'(rsp_byte), 32'(prev_byte));
            if (req_ready !== 1'b0) bad_rr++;
            if (rsp_ready) got.push_back(rsp_byte);
            prev_stall = !rsp_ready;
            prev_byte  = rsp_byte;
         end
         @(negedge clk);
         off++;
      end
      rsp_ready = 1'b1;
      check({tag, "_lat"}, 32'(first_valid), exp_err ? 32'd1 : 32'd2);
      check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         obs = (i < got.size()) ? got[i] : 8'hxx;
         check({tag, "_byte"}, 32'(obs), 32'(exp_q[i]));
      end
      check({tag, "_ferr"}, 32'(err_cnt - e0), 32'(exp_err));
      check({tag, "_rr_busy"}, 32'(bad_rr), 32'd0);
      check({tag, "_rr_back"}, 32'(req_ready), 32'd1);
      check({tag, "_rv_done"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int          first_k;
      int          rsp_seen;
      int          e0;
      int          r;
      int          idx;
      logic        rr_at;
      logic [7:0]  c;
      logic [31:0] a32;
      logic [31:0] d32;
      bit          stall;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_byte  = 8'h00;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_byte", 32'(rsp_byte), 32'h00);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_frame("wr10", 1'b0, 0);
      frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10};
      run_frame("rd10", 1'b0, 0);
      run_frame("rd10_bp", 1'b1, 0);

      frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'hCA, 8'hFE, 8'h00, 8'h42};
      run_frame("wr04", 1'b0, 1);
      frm = '{8'h7F};
      run_frame("badcmd", 1'b0, 0);
      frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h06};
      run_frame("misalign", 1'b0, 0);
      frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
      run_frame("rd04", 1'b1, 0);

      frm = '{8'h02, 8'h00, 8'h00, 8'h04, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
      run_frame("wr400", 1'b0, 0);
      frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame("rd000_alias", 1'b0, 0);

      // Abandoned frame: no byte for TIMEOUT cycles after the third byte.
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      first_k  = -1;
      rsp_seen = 0;
      rr_at    = 1'b0;
      e0       = err_cnt;
      for (int k = 1; k <= TIMEOUT + 5; k++) begin
         @(negedge clk);
         if (frame_err === 1'b1 && first_k < 0) begin
            first_k = k;
            rr_at   = req_ready;
         end
         if (rsp_valid !== 1'b0) rsp_seen++;
      end
      check("tmo_when", 32'(first_k), 32'(TIMEOUT));
      check("tmo_req_ready", 32'(rr_at), 32'd1);
      check("tmo_no_rsp", 32'(rsp_seen), 32'd0);
      check("tmo_pulses", 32'(err_cnt - e0), 32'd1);
      frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10};
      run_frame("rd10_after_tmo", 1'b0, 0);

      // Reset while the second data byte of a write is offered.
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h10, 0);
      send_byte(8'h11, 0);
      req_valid = 1'b1;
      req_byte  = 8'h22;
      rst       = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      check("rstmid_req_ready", 32'(req_ready), 32'd1);
      check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10};
      run_frame("rd10_after_rst", 1'b0, 0);

      // Reset while a read response is stalled.
      rsp_ready = 1'b0;
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h10, 0);
      repeat (2) @(negedge clk);
      check("rstrsp_pre_valid", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      check("rstrsp_valid", 32'(rsp_valid), 32'd0);
      check("rstrsp_req_ready", 32'(req_ready), 32'd1);

      for (int f = 0; f < 40; f++) begin
         r     = int'($urandom_range(0, 9));
         stall = 1'($urandom_range(0, 1));
         a32   = $urandom & 32'hFFFF_FFFC;
         frm.delete();
         if (r == 0) begin
            c = 8'($urandom);
            if (c == 8'h01 || c == 8'h02) c = c ^ 8'h80;
            frm.push_back(c);
         end else if (r == 1) begin
            frm.push_back(($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02);
            a32 = a32 | 32'($urandom_range(1, 3));
            frm.push_back(a32[31:24]);
            frm.push_back(a32[23:16]);
            frm.push_back(a32[15:8]);
            frm.push_back(a32[7:0]);
         end else if (r <= 5 || known_q.size() == 0) begin
            d32 = $urandom;
            frm.push_back(8'h02);
            frm.push_back(a32[31:24]);
            frm.push_back(a32[23:16]);
            frm.push_back(a32[15:8]);
            frm.push_back(a32[7:0]);
            frm.push_back(d32[31:24]);
            frm.push_back(d32[23:16]);
            frm.push_back(d32[15:8]);
            frm.push_back(d32[7:0]);
         end else begin
            idx = known_q[$urandom_range(0, known_q.size() - 1)];
            a32 = ($urandom << (ADDR_W + 2)) | (32'(idx) << 2);
            frm.push_back(8'h01);
            frm.push_back(a32[31:24]);
            frm.push_back(a32[23:16]);
            frm.push_back(a32[15:8]);
            frm.push_back(a32[7:0]);
         end
         run_frame("rnd", stall, int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
